// File: rtl/ahb_sram_slv.sv
// AHB-lite single-port SRAM slave: wait-state insertion, byte-lane writes, registered read with write-first forwarding.
// Optional AHB_SLV_ERR_EN: misaligned, oversized or out-of-range accesses get a two-cycle ERROR response.
`ifndef HADDR_BUS
`define HADDR_BUS 31:0
`endif
`ifndef HDATA_BUS
`define HDATA_BUS 31:0
`endif

module ahb_sram_slv #(
   parameter int unsigned MEM_AW      = 12,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              slv_hsel_i,
   input  logic [1:0]        slv_htrans_i,
   input  logic [`HADDR_BUS] slv_haddr_i,
   input  logic              slv_hwrite_i,
   input  logic [2:0]        slv_hsize_i,
   input  logic [2:0]        slv_hburst_i,
   input  logic [3:0]        slv_hprot_i,
   input  logic              slv_hmastlock_i,
   input  logic [`HDATA_BUS] slv_hwdata_i,
   input  logic              slv_hready_i,
   output logic              slv_hreadyout_o,
   output logic              slv_hresp_o,
   output logic [`HDATA_BUS] slv_hrdata_o
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic              write_q, write_d;

   logic [31:0]       mem [2**MEM_AW];
   logic [31:0]       rd_q, fwd_dat_q, rd_data;
   logic [3:0]        fwd_be_q;

   logic [31:0]       offset;
   logic              accept, err_req, wr_en;
   logic [3:0]        be_req;
   logic [MEM_AW-1:0] rd_addr;
   logic              unused_ok;

   assign offset    = slv_haddr_i - BASE_ADDR;
   assign accept    = slv_hsel_i && slv_htrans_i[1] && slv_hready_i &&
                      (state_q inside {S_IDLE, S_DATA, S_ERR2});
   // Read is launched at accept (zero-wait) or from the captured address while waiting.
   assign rd_addr   = accept ? offset[MEM_AW+1:2] : addr_q;
   assign wr_en     = (state_q == S_DATA) && write_q && !rst;
   assign unused_ok = ^{slv_hburst_i, slv_hprot_i, slv_hmastlock_i, offset};

   always_comb begin
      case (slv_hsize_i)
         3'b000:  be_req = 4'b0001 << offset[1:0];
         3'b001:  be_req = offset[1] ? 4'b1100 : 4'b0011;
         default: be_req = 4'b1111;
      endcase
   end

`ifdef AHB_SLV_ERR_EN
   assign err_req = (slv_hsize_i > 3'b010) ||
                    ((slv_hsize_i == 3'b001) && offset[0]) ||
                    ((slv_hsize_i == 3'b010) && (offset[1:0] != 2'b00)) ||
                    (|offset[31:MEM_AW+2]);
`else
   assign err_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         write_q <= write_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      write_d = write_q;
      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            state_d = S_IDLE;
            if (accept) begin
               addr_d  = offset[MEM_AW+1:2];
               be_d    = be_req;
               write_d = slv_hwrite_i;
               cnt_d   = WAIT_LOAD;
               if (err_req)              state_d = S_ERR1;
               else if (WAIT_STATES > 0) state_d = S_WAIT;
               else                      state_d = S_DATA;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   // Read-first array; a same-cycle write to the read word is merged below per lane.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && be_q[i]) mem[addr_q][8*i +: 8] <= slv_hwdata_i[8*i +: 8];
      end
      rd_q      <= mem[rd_addr];
      fwd_be_q  <= (wr_en && (addr_q == rd_addr)) ? be_q : 4'd0;
      fwd_dat_q <= slv_hwdata_i;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
         assign rd_data[8*gi +: 8] = fwd_be_q[gi] ? fwd_dat_q[8*gi +: 8] : rd_q[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      slv_hreadyout_o = 1'b1;
      slv_hresp_o     = 1'b0;
      slv_hrdata_o    = '0;
      case (state_q)
         S_WAIT: slv_hreadyout_o = 1'b0;
         S_DATA: slv_hrdata_o    = rd_data;
         S_ERR1: begin
            slv_hreadyout_o = 1'b0;
            slv_hresp_o     = 1'b1;
         end
         S_ERR2:  slv_hresp_o = 1'b1;
         default: ;
      endcase
   end
endmodule
